// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU requesters, the response consumer and alu_arbiter.
// master = requester/consumer side, slave = arbiter side.
interface alu_arbiter_if #(
  parameter int CNT_W = 16
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [31:0]      req0_a;
  logic [31:0]      req0_b;
  logic [31:0]      req1_a;
  logic [31:0]      req1_b;
  logic [3:0]       req0_op;
  logic [3:0]       req1_op;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [31:0]      resp_result;
  logic             resp_err;
  logic [CNT_W-1:0] op_count;

  modport master (
    output req_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_result, resp_err, op_count
  );

  modport slave (
    input  req_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op, resp_ready,
    output req_ready, resp_valid, resp_id, resp_result, resp_err, op_count
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one single-cycle 32-bit ALU between two requesters; result lands in a
// registered response port one edge after accept. Define ALU_ARB_OPCHK_EN to flag illegal opcodes on resp_err.
module alu_arbiter #(
  parameter int NREQ  = 2,
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NREQ);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SLL = 4'h5;
  localparam logic [3:0] OP_SRL = 4'h6;

  function automatic logic [31:0] alu_eval(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op);
    logic [31:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << b[4:0];
      OP_SRL:  r = a >> b[4:0];
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_id_q, resp_id_d;
  logic [31:0]      resp_result_q, resp_result_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic        accept_en;
  logic [1:0]  grant;
  logic [1:0]  req_ready;
  logic        accept;
  logic        sel;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [3:0]  op_code;
  logic [31:0] alu_res;

  // Grant is gated by rst_n so nothing is handshaken while reset is held.
  always_comb begin
    accept_en = !resp_valid_q || bus.resp_ready;
    if (bus.req_valid == 2'b11) begin
      grant = (ptr_q == IDX_W'(1)) ? 2'b10 : 2'b01;
    end else begin
      grant = bus.req_valid;
    end
    req_ready = (rst_n && accept_en) ? grant : 2'b00;
    accept    = |req_ready;
    sel       = req_ready[1];
    op_a      = sel ? bus.req1_a  : bus.req0_a;
    op_b      = sel ? bus.req1_b  : bus.req0_b;
    op_code   = sel ? bus.req1_op : bus.req0_op;
    alu_res   = alu_eval(op_a, op_b, op_code);
  end

  always_comb begin
    ptr_d         = ptr_q;
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    op_count_d    = op_count_q;
    if (accept) begin
      resp_valid_d  = 1'b1;
      resp_id_d     = sel;
      resp_result_d = alu_res;
      ptr_d         = sel ? IDX_W'(0) : IDX_W'(1);
      op_count_d    = op_count_q + CNT_W'(1);
    end else if (bus.resp_ready) begin
      resp_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q         <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_result_q <= 32'h0;
      op_count_q    <= '0;
    end else begin
      ptr_q         <= ptr_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
      op_count_q    <= op_count_d;
    end
  end

`ifdef ALU_ARB_OPCHK_EN
  logic resp_err_q, resp_err_d;
  logic op_illegal;

  // Illegal opcodes are still accepted and counted; they only raise the flag.
  always_comb begin
    op_illegal = op_code[3] || (op_code[2:0] == 3'b111);
    resp_err_d = resp_err_q;
    if (accept) begin
      resp_err_d = op_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_err_q <= 1'b0;
    end else begin
      resp_err_q <= resp_err_d;
    end
  end

  assign bus.resp_err = resp_err_q;
`else
  assign bus.resp_err = 1'b0;
`endif

  assign bus.req_ready   = req_ready;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_id     = resp_id_q;
  assign bus.resp_result = resp_result_q;
  assign bus.op_count    = op_count_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios then random traffic, all checked against a
// cycle-level reference model of the arbitration and ALU rules.
module tb_alu_arbiter;
  localparam int CNT_W = 4;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  alu_arbiter_if #(.CNT_W(CNT_W)) bus ();

  alu_arbiter #(.NREQ(2), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  bit          m_vld;
  bit          m_id;
  logic [31:0] m_res;
  bit          m_err;
  int          m_last;
  int          m_cnt;
  logic [1:0]  smp_rdy;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    int sh;
    sh = int'(b % 32);
    if (op == 0) return a + b;
    if (op == 1) return a - b;
    if (op == 2) return a & b;
    if (op == 3) return a | b;
    if (op == 4) return a ^ b;
    if (op == 5) return a << sh;
    if (op == 6) return a >> sh;
    return 32'h0;
  endfunction

  function automatic bit ref_err(input logic [3:0] op);
`ifdef ALU_ARB_OPCHK_EN
    return op > 6;
`else
    return (op > 6) && 1'b0;
`endif
  endfunction

  // One clock: check combinational ready before the edge, advance the model, check registers after it.
  task automatic step(output int win);
    logic [1:0]  exp_rdy;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    win = -1;
    @(negedge clk);
    if (rst_n && (!m_vld || bus.resp_ready)) begin
      if (bus.req_valid == 2'b11) win = 1 - m_last;
      else if (bus.req_valid[0]) win = 0;
      else if (bus.req_valid[1]) win = 1;
    end
    exp_rdy = 2'b00;
    if (win >= 0) exp_rdy[win] = 1'b1;
    smp_rdy = bus.req_ready;
    chk("req_ready", bus.req_ready, exp_rdy);
    if (!rst_n) begin
      m_vld = 0; m_id = 0; m_res = 0; m_err = 0; m_last = 1; m_cnt = 0;
    end else if (win >= 0) begin
      a  = (win == 1) ? bus.req1_a  : bus.req0_a;
      b  = (win == 1) ? bus.req1_b  : bus.req0_b;
      op = (win == 1) ? bus.req1_op : bus.req0_op;
      m_vld  = 1;
      m_id   = (win == 1);
      m_res  = ref_alu(a, b, op);
      m_err  = ref_err(op);
      m_last = win;
      m_cnt  = (m_cnt + 1) % (1 << CNT_W);
    end else if (bus.resp_ready) begin
      m_vld = 0;
    end
    @(posedge clk);
    #1;
    chk("resp_valid", bus.resp_valid, m_vld);
    chk("resp_id", bus.resp_id, m_id);
    chk("resp_result", bus.resp_result, m_res);
    chk("resp_err", bus.resp_err, m_err);
    chk("op_count", bus.op_count, m_cnt);
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op);
    if (i == 0) begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end else begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end
  endtask

  int          w;
  int          ids[4];
  logic [31:0] res[4];
  bit          pend[2];

  initial begin
    n_chk = 0;
    n_err = 0;
    m_vld = 0; m_id = 0; m_res = 0; m_err = 0; m_last = 1; m_cnt = 0;
    rst_n = 1'b0;
    bus.req_valid  = 2'b00;
    bus.resp_ready = 1'b0;
    set_req(0, 0, 0, 0);
    set_req(1, 0, 0, 0);
    step(w);
    step(w);
    chk("rst_valid", bus.resp_valid, 0);
    chk("rst_count", bus.op_count, 0);

    // Single add on req0
    rst_n = 1'b1;
    set_req(0, 5, 3, 4'h0);
    bus.req_valid  = 2'b01;
    bus.resp_ready = 1'b1;
    step(w);
    chk("t1_rdy", smp_rdy, 2'b01);
    chk("t1_res", bus.resp_result, 8);
    chk("t1_id", bus.resp_id, 0);
    chk("t1_cnt", bus.op_count, 1);

    // Solo req1 hands priority back to req0
    bus.req_valid = 2'b10;
    set_req(1, 32'h9, 32'h6, 4'h4);
    step(w);
    chk("solo1_res", bus.resp_result, 32'hF);
    chk("solo1_id", bus.resp_id, 1);

    // Both valid: strict alternation
    set_req(0, 10, 3, 4'h1);
    set_req(1, 1, 32'h24, 4'h5);
    bus.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      step(w);
      ids[k] = int'(bus.resp_id);
      res[k] = bus.resp_result;
    end
    for (int k = 0; k < 4; k++) begin
      chk("alt_id", ids[k], k % 2);
      chk("alt_res", res[k], (k % 2 == 0) ? 32'd7 : 32'h10);
    end

    // Backpressure
    bus.req_valid = 2'b00;
    step(w);
    bus.resp_ready = 1'b0;
    bus.req_valid  = 2'b10;
    set_req(1, 32'hF0F0F0F0, 32'hFF00FF00, 4'h2);
    step(w);
    chk("bp_acc", w, 1);
    set_req(1, 32'hF0F0F0F0, 32'hFF00FF00, 4'h3);
    for (int k = 0; k < 3; k++) begin
      step(w);
      chk("bp_rdy", smp_rdy, 2'b00);
      chk("bp_hold", bus.resp_result, 32'hF000F000);
    end
    bus.resp_ready = 1'b1;
    step(w);
    chk("bp_drain_rdy", smp_rdy, 2'b10);
    chk("bp_drain_vld", bus.resp_valid, 1);
    chk("bp_drain_res", bus.resp_result, 32'hFFF0FFF0);

    // Illegal opcode
    bus.req_valid = 2'b01;
    set_req(0, 32'h1234, 32'h5678, 4'hA);
    step(w);
    chk("ill_res", bus.resp_result, 0);
`ifdef ALU_ARB_OPCHK_EN
    chk("ill_err", bus.resp_err, 1);
`else
    chk("ill_err", bus.resp_err, 0);
`endif

    // Reset while a response is stalled
    bus.resp_ready = 1'b0;
    set_req(0, 1, 1, 4'h0);
    step(w);
    chk("mid_vld", bus.resp_valid, 1);
    rst_n = 1'b0;
    bus.req_valid = 2'b11;
    step(w);
    chk("mid_rdy", smp_rdy, 2'b00);
    chk("mid_vld0", bus.resp_valid, 0);
    chk("mid_cnt0", bus.op_count, 0);
    rst_n = 1'b1;
    bus.resp_ready = 1'b1;
    step(w);
    chk("mid_first", bus.resp_id, 0);

    // Counter wrap: 17 accepts from reset
    rst_n = 1'b0;
    step(w);
    rst_n = 1'b1;
    bus.req_valid = 2'b01;
    for (int k = 0; k < 17; k++) begin
      set_req(0, $urandom, $urandom, 4'($urandom_range(0, 6)));
      step(w);
    end
    chk("wrap_cnt", bus.op_count, 1);

    // Random traffic; requests held until accepted
    pend[0] = 0;
    pend[1] = 0;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && ($urandom_range(0, 2) != 0)) begin
          pend[i] = 1;
          set_req(i, $urandom, ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40)),
                  4'($urandom_range(0, 15)));
        end
      end
      bus.req_valid  = {pend[1], pend[0]};
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      rst_n          = ($urandom_range(0, 99) != 0);
      step(w);
      if (w >= 0) pend[w] = 0;
    end
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single-cycle 32-bit integer ALU between two requesters, requester 0 and requester 1, on the execute-stage side of the core. Each requester uses a valid/ready handshake. The block arbitrates round-robin between them and evaluates the winner's operation on an internally instantiated ALU datapath. It returns the result through one registered response port that carries a requester ID and supports backpressure.

## Interface
- `NREQ`, default 2: number of requesters. Fixed at 2; any other value is unsupported.
- `CNT_W`, default 16: width of the accepted-operation counter.

Ports (clock and reset first):
- `clk` input 1: the single clock. All state updates on the rising edge.
- `rst_n` input 1: reset. Synchronous, active-low.
- `req_valid` input [1:0]: per-requester operation valid.
- `req_ready` output [1:0]: per-requester accept. One-hot or zero.
- `req0_a`, `req0_b` input 32: operands for requester 0.
- `req1_a`, `req1_b` input 32: operands for requester 1.
- `req0_op`, `req1_op` input 4: opcodes, using the ALU encoding (below).
- `resp_valid` output 1: response register holds a result.
- `resp_ready` input 1: consumer accepts the response.
- `resp_id` output 1: requester index that owns the response.
- `resp_result` output 32: ALU result.
- `resp_err` output 1: illegal-opcode flag. Only meaningful with `ALU_ARB_OPCHK_EN` defined.
- `op_count` output CNT_W: number of accepted operations, wrapping.

## Operation
- Opcode encoding and result:
  - 0000: add.
  - 0001: sub.
  - 0010: and.
  - 0011: or.
  - 0100: xor.
  - 0101: shift left logical by `b[4:0]`.
  - 0110: shift right logical by `b[4:0]`.
  - 0111 to 1111: result 0.
- Add and sub wrap modulo 2^32. No carry or overflow output.
- `accept_en = !resp_valid || resp_ready`. The response register is free, or is being drained in this cycle.
- Grant:
  - Only one `req_valid` set: that requester wins.
  - Both set: requester `ptr` wins.
  - None set: no grant.
- `req_ready[i] = accept_en && grant[i]`.
  - Combinational from `req_valid`, `ptr`, `resp_valid` and `resp_ready`.
  - `req_ready[i]` never asserts while `req_valid[i]=0`.
- Accept happens when `req_valid[i] && req_ready[i]`. On accept:
  - The selected a/b/op are evaluated combinationally in the same cycle.
  - `resp_result`, `resp_id` and `resp_err` are registered.
  - `resp_valid` is set to 1.
  - `ptr` becomes the other requester's index.
  - `op_count` increments.
- Response handshake with no accept in the same cycle: `resp_valid` clears. `resp_result`, `resp_id` and `resp_err` keep their values.
- Response handshake and accept in the same cycle: the register reloads with the new operation and `resp_valid` stays 1.
- While `resp_valid && !resp_ready`:
  - `req_ready` is 0.
  - The response outputs are held stable.
  - `ptr` does not change.
- Requesters must hold valid, operands and op stable until accepted. Behaviour when a requester drops an unaccepted request is don't-care to the block, and it raises no assertion.

## Timing
- Reset (`rst_n=0` sampled at an edge) sets:
  - `resp_valid=0`, `resp_id=0`, `resp_result=0`, `resp_err=0`.
  - `ptr=0`, `op_count=0`.
- `req_ready` is 0 in any cycle in which `rst_n=0`.
- A response pending when reset asserts is discarded, and no handshake occurs.
- Latency: accept at edge N, so `resp_valid=1` is visible after edge N.
- Throughput: one operation per cycle when `resp_ready` is held at 1.
- Fairness: while both requesters are continuously valid, grants strictly alternate.
- `op_count` wraps from 2^CNT_W−1 to 0.

## Configuration
- `ALU_ARB_OPCHK_EN` defined:
  - Opcodes 0111 to 1111 register `resp_err=1` with `resp_result=0`.
  - Legal opcodes register `resp_err=0`.
  - The operation is still accepted, counted, and returned like any other.
- `ALU_ARB_OPCHK_EN` undefined:
  - The checking logic is not compiled in.
  - `resp_err` is tied to 0.
  - Illegal opcodes return `resp_result=0`.

## Test plan
- Reset release, then a single request: req0 with a=5, b=3, op=0000 and `resp_ready=1`.
  - Expect `req_ready=01` that cycle.
  - Next cycle expect `resp_valid=1`, `resp_id=0`, `resp_result=8`, `op_count=1`.
- Both requesters valid for 4 cycles with `resp_ready=1`: req0 op=0001 (10−3), req1 op=0101 (a=1, b=0x24).
  - Expect ids 0,1,0,1 in order.
  - Expect results 7, 0x10, 7, 0x10.
  - Note the shift uses only `b[4:0]`=4.
- Backpressure: `resp_ready=0` with req1 valid, a=0xF0F0F0F0, b=0xFF00FF00, op=0010.
  - Expect `resp_result=0xF000F000` held and `req_ready=00` for 3 cycles.
  - Raise `resp_ready`: expect the next request accepted in the same cycle as the drain, and `resp_valid` stays 1.
- Illegal opcode 1010 on req0.
  - Expect `resp_result=0`.
  - Expect `resp_err=1` only with `ALU_ARB_OPCHK_EN` defined, otherwise 0.
- Reset mid-operation: `rst_n=0` while `resp_valid=1`, `resp_ready=0`.
  - Next cycle expect `resp_valid=0`, `op_count=0`, `ptr=0`.
  - With both requesters valid after release, the first grant goes to req0.
- Counter wrap at CNT_W=4: 17 accepted operations, then expect `op_count=1`.
